// File: rtl/uart_word_rx_if.sv
// Bus between the serial line, the word receiver and its system-side sink.
//
// Handshake: sys_rx_data_valid is a one-cycle strobe with no ready/back-pressure.
// The sink must capture o_sys_data in the cycle the strobe is high. o_sys_data
// holds its value until the next word completes. o_frame_err is an independent
// one-cycle strobe. o_rx_busy is a level.
interface uart_word_rx_if;
  logic        i_rx;
  logic [31:0] o_sys_data;
  logic        sys_rx_data_valid;
  logic        o_frame_err;
  logic        o_rx_busy;

  // Receiver side: consumes the serial line and produces the word outputs.
  modport master (
    input  i_rx,
    output o_sys_data,
    output sys_rx_data_valid,
    output o_frame_err,
    output o_rx_busy
  );

  // Line driver / system sink side.
  modport slave (
    output i_rx,
    input  o_sys_data,
    input  sys_rx_data_valid,
    input  o_frame_err,
    input  o_rx_busy
  );
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that assembles four bytes (LSB first) into a 32-bit word.
// A partial word is dropped on a bad stop bit or after a long idle gap.
module uart_word_rx #(
  parameter int CLKS_PER_BIT      = 27,
  parameter int WORD_TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_word_rx_if.master bus,
  output logic [2:0]     dbg_state
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF      = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]   LAST      = CW'(CLKS_PER_BIT - 1);
  localparam int              TO_CYCLES = WORD_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int              IW        = $clog2(TO_CYCLES);
  localparam logic [IW-1:0]   TO_LAST   = IW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s, rx_prev;
  logic [1:0]    sync_fill;
  logic          fall;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    shift_reg;
  logic [31:0]   word_buf;
  logic [IW-1:0] idle_cnt;
  logic          idle_run, timeout;
  logic [31:0]   data_q;
  logic          valid_q, ferr_q;

  // FSM control strobes
  logic cnt_clr, shift_en, byte_ok, frame_bad;

  // Two-flop synchronizer plus edge-detect history. sync_fill keeps edge
  // detection off until the reset values have been flushed, so a line that is
  // already low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'd0;
    end else begin
      rx_meta <= bus.i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (sync_fill != 2'd3) sync_fill <= sync_fill + 2'd1;
    end
  end

  assign fall = (sync_fill == 2'd3) && rx_prev && !rx_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          cnt_clr   = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_cnt == HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        // Counter was re-phased at mid-start, so LAST lands on mid-bit.
        if (baud_cnt == LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_cnt == LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            byte_ok   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Baud counter: free-runs only while a frame is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     baud_cnt <= '0;
    else if (cnt_clr || state == S_IDLE || state == S_BREAK) baud_cnt <= '0;
    else                                            baud_cnt <= baud_cnt + 1'b1;
  end

  // Bit counter and byte shift register (LSB arrives first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
    end else if (fall && state == S_IDLE) begin
      bit_cnt <= 3'd0;
    end else if (shift_en) begin
      bit_cnt   <= bit_cnt + 3'd1;
      shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  // Idle timer for a partial word; leaving IDLE (any start edge) clears it
  assign idle_run = (state == S_IDLE) && (byte_cnt != 2'd0);
  assign timeout  = idle_run && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          idle_cnt <= '0;
    else if (!idle_run || fall || timeout) idle_cnt <= '0;
    else                                 idle_cnt <= idle_cnt + 1'b1;
  end

  // Byte lane counter; a coincident timeout still clears it so the new
  // byte starts a fresh word in lane 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         byte_cnt <= 2'd0;
    else if (frame_bad) byte_cnt <= 2'd0;
    else if (byte_ok)   byte_cnt <= byte_cnt + 2'd1;
    else if (timeout)   byte_cnt <= 2'd0;
  end

  // Word assembly and registered output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_buf <= 32'd0;
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= frame_bad;
      if (byte_ok) begin
        word_buf[{byte_cnt, 3'b000} +: 8] <= shift_reg;
        if (byte_cnt == 2'd3) begin
          data_q  <= {shift_reg, word_buf[23:0]};
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_sys_data        = data_q;
  assign bus.sys_rx_data_valid = valid_q;
  assign bus.o_frame_err       = ferr_q;
  assign bus.o_rx_busy         = (state != S_IDLE) || (byte_cnt != 2'd0);
  assign dbg_state             = state;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: drives 8N1 frames and checks the assembled
// words, strobes and busy flag against hand-computed values.
module tb_uart_word_rx;

  localparam int CPB = 27;
  localparam int TOB = 20;

  logic clk;
  logic rst_n;
  logic [2:0] dbg_state;

  uart_word_rx_if u_if ();

  uart_word_rx #(
    .CLKS_PER_BIT      (CPB),
    .WORD_TIMEOUT_BITS (TOB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (u_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int valid_long = 0;
  int hold_viol = 0;
  int valid_cyc = 0;
  int fall_cyc = 0;
  logic prev_valid = 1'b0;
  logic [31:0] prev_data = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: sample away from the active edge
  always @(negedge clk) begin
    if (u_if.sys_rx_data_valid) begin
      got_q.push_back(u_if.o_sys_data);
      valid_cyc = cyc;
      if (prev_valid) valid_long++;
    end
    if (u_if.o_frame_err) ferr_cnt++;
    if (rst_n && !u_if.sys_rx_data_valid && (u_if.o_sys_data !== prev_data)) hold_viol++;
    prev_valid = u_if.sys_rx_data_valid;
    prev_data  = u_if.o_sys_data;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    u_if.i_rx = 1'b0;
    fall_cyc  = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    u_if.i_rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic verify_words(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst_n     = 1'b0;
    u_if.i_rx = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check_eq("rst_data",  u_if.o_sys_data, 32'd0);
    check_eq("rst_valid", u_if.sys_rx_data_valid, 1'b0);
    check_eq("rst_ferr",  u_if.o_frame_err, 1'b0);
    check_eq("rst_busy",  u_if.o_rx_busy, 1'b0);
    check_eq("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post_rst_busy", u_if.o_rx_busy, 1'b0);

    // Single word, back-to-back bytes, plus latency from the 4th start edge
    exp_q.push_back(32'h66666666);
    send_word(32'h66666666);
    lat = valid_cyc - fall_cyc;
    check_eq("latency_ok", (lat >= 259 && lat <= 262), 1'b1);
    repeat (20) @(negedge clk);
    check_eq("single_data", u_if.o_sys_data, 32'h66666666);
    check_eq("single_ferr", ferr_cnt, 0);
    check_eq("single_busy", u_if.o_rx_busy, 1'b0);
    verify_words("single");

    // Byte order and repeat; earlier word must hold during the next word
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hFFFFFFFF);
    send_word(32'h12345678);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    check_eq("order_hold", u_if.o_sys_data, 32'h12345678);
    check_eq("order_busy_partial", u_if.o_rx_busy, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    verify_words("order");

    // Start glitch: 5 low cycles must not start a frame
    u_if.i_rx = 1'b0;
    repeat (5) @(negedge clk);
    u_if.i_rx = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("glitch_busy", u_if.o_rx_busy, 1'b0);
    check_eq("glitch_ferr", ferr_cnt, 0);
    exp_q.push_back(32'hA5A5A5A5);
    send_word(32'hA5A5A5A5);
    repeat (20) @(negedge clk);
    verify_words("glitch");

    // Frame error: bad stop bit then line held low (break)
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check_eq("break_state", dbg_state, 3'd4);
    u_if.i_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_eq("ferr_count", ferr_cnt, 1);
    check_eq("ferr_busy", u_if.o_rx_busy, 1'b0);
    exp_q.push_back(32'h04030201);
    send_word(32'h04030201);
    repeat (20) @(negedge clk);
    check_eq("ferr_count_after", ferr_cnt, 1);
    verify_words("ferr");

    // Word timeout after a partial word
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("to_busy_partial", u_if.o_rx_busy, 1'b1);
    repeat (19 * CPB - 5) @(negedge clk);
    check_eq("to_busy_before", u_if.o_rx_busy, 1'b1);
    repeat (6 * CPB) @(negedge clk);
    check_eq("to_busy_after", u_if.o_rx_busy, 1'b0);
    exp_q.push_back(32'hDDCCBBAA);
    send_word(32'hDDCCBBAA);
    repeat (20) @(negedge clk);
    verify_words("timeout");

    // Reset during data bits of byte 2; line low at release
    send_byte(8'h3C, 1'b1);
    u_if.i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      u_if.i_rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    u_if.i_rx = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_data",  u_if.o_sys_data, 32'd0);
    check_eq("mid_rst_valid", u_if.sys_rx_data_valid, 1'b0);
    check_eq("mid_rst_busy",  u_if.o_rx_busy, 1'b0);
    check_eq("mid_rst_state", dbg_state, 3'd0);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("low_release_busy",  u_if.o_rx_busy, 1'b0);
    check_eq("low_release_state", dbg_state, 3'd0);
    u_if.i_rx = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    repeat (20) @(negedge clk);
    check_eq("rst_word_data", u_if.o_sys_data, 32'hCAFEF00D);
    verify_words("reset");

    // Global pulse-shape and hold properties
    check_eq("valid_one_cycle", valid_long, 0);
    check_eq("data_hold", hold_viol, 0);
    check_eq("ferr_total", ferr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial-to-word receiver for the 32-bit UART link: it samples an 8N1 serial line, recovers bytes and assembles four consecutive bytes, least-significant byte first, into one 32-bit word. It sits at the receive end of the link, opposite the word transmitter that splits `i_sys_data` into four UART bytes. It presents the word to the system side with a one-cycle `sys_rx_data_valid` strobe. The default timing targets a 25 MHz clock at 921600 baud.

## Interface
- `CLKS_PER_BIT`, 27: clock cycles per serial bit; legal range 8..1023.
- `WORD_TIMEOUT_BITS`, 20: idle bit-times after which a partially received word is discarded; legal range 12..255.
- `clk`  in  1  system clock. One clock domain; all flops are clocked on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_rx`  in  1  serial line; idle high; asynchronous to `clk`.
- `o_sys_data`  out  32  last complete word; holds until the next word completes.
- `sys_rx_data_valid`  out  1  one-cycle pulse when `o_sys_data` is updated.
- `o_frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `o_rx_busy`  out  1  high while a byte is in flight or a partial word is held.

## Operation
- `i_rx` passes through a 2-flop synchronizer; both stages reset to 1. All logic uses the synchronized value `rx_s`.
- Bit counter and byte counter: 3 bits and 2 bits. Baud counter: `clog2(CLKS_PER_BIT)` bits, counting 0..CLKS_PER_BIT-1.
- **IDLE**
  - A falling edge of `rx_s` (previous 1, current 0) clears the baud counter and goes to START.
- **START**
  - At count CLKS_PER_BIT/2 (integer divide), `rx_s` is sampled.
  - If `rx_s`=0: clear the counter and go to DATA.
  - If `rx_s`=1: treat as a glitch and return to IDLE; no output is produced.
- **DATA**
  - Each time the counter reaches CLKS_PER_BIT-1, sample `rx_s` (this is mid-bit) and shift it into the byte register, LSB first.
  - After 8 bits, go to STOP.
- **STOP**
  - At mid-bit, sample `rx_s`.
  - If 1: the byte is good. Write it into word lane `byte_cnt` (lane 0 = bits [7:0]) and increment `byte_cnt`. If `byte_cnt` was 3, copy the assembled word to `o_sys_data` and pulse `sys_rx_data_valid`; `byte_cnt` wraps to 0. Go to IDLE.
  - If 0: pulse `o_frame_err`, clear `byte_cnt` (the partial word is dropped) and go to BREAK.
- **BREAK**
  - Wait until `rx_s`=1, then go to IDLE. A held-low line never starts a new frame.
- **Word timeout**
  - When `byte_cnt`≠0 and the FSM is in IDLE, an idle counter runs.
  - After WORD_TIMEOUT_BITS×CLKS_PER_BIT cycles, clear `byte_cnt`. No pulse is issued.
  - The counter is cleared by any start edge.
- `o_rx_busy` = (state≠IDLE) or (`byte_cnt`≠0).

## Timing
- Reset values:
  - `o_sys_data` = 0.
  - `sys_rx_data_valid`, `o_frame_err` and `o_rx_busy` = 0.
  - FSM in IDLE; all counters = 0.
- Reset asserted mid-frame aborts immediately. After release, the block waits for a fresh falling edge; a line already low at release is not a start edge.
- `sys_rx_data_valid` and `o_frame_err` are registered. They go high the cycle after the stop-bit sample and stay high for exactly one cycle.
- `o_sys_data` changes on the same edge that raises `sys_rx_data_valid`. It is stable for at least 4 frames afterwards.
- Latency: from the falling edge of the 4th start bit on `i_rx`, valid rises after 2 + 9.5×CLKS_PER_BIT + 2 cycles, ±1 cycle.
- The FSM returns to IDLE at mid-stop-bit. Back-to-back frames with no idle gap are received without loss.
- A falling edge while in BREAK is ignored.
- A timeout and a start edge in the same cycle: the start wins. The start edge clears the idle counter, and the new byte lands in lane 0.

## Test plan
- **Single word.** Send bytes 66,66,66,66 back-to-back at CLKS_PER_BIT=27 → `o_sys_data`=0x66666666 with exactly one `sys_rx_data_valid` pulse; `o_frame_err` stays 0.
- **Byte order and repeat.** Send 78,56,34,12, then FF,FF,FF,FF → words 0x12345678 then 0xFFFFFFFF, two valid pulses; `o_sys_data` holds 0x12345678 between the pulses.
- **Start glitch.** Drive `i_rx` low for 5 cycles, then send 4 bytes of A5 → no output from the glitch, then 0xA5A5A5A5 with one pulse.
- **Frame error.** Send 11,22 with a 0 stop bit on the second byte, hold low for 3 bit-times, release, then send 01,02,03,04 → one `o_frame_err` pulse, then a single word 0x04030201.
- **Timeout.** Send 2 bytes, idle for 25 bit-times, then send AA,BB,CC,DD → `o_rx_busy` drops to 0 at the timeout; only 0xDDCCBBAA is delivered.
- **Reset mid-operation.** Assert `rst_n`=0 during the data bits of byte 2 of a word; after release, send a full word 0xCAFEF00D → all outputs return to reset values, then 0xCAFEF00D is delivered correctly.
